trap_ctrl: RTL and testbench

Machine-mode trap sequencer that drives the trap/mret side of CSRRegs and redirects the pipeline. Samples the MEM-stage instruction's exception flags, pending external interrupt and mret, and latches cause/epc/tval. It then commits the event into the CSR file, avoiding collisions with CSR instruction writes. Finally it issues a flush plus PC redirect to mtvec or mepc.

---
 rtl/trap_ctrl_if.sv | 44 ++++
 rtl/trap_ctrl.sv | 106 ++++++++++
 tb/tb_trap_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// rtl/trap_ctrl_if.sv - MEM-stage, CSR-file and redirect signals of the trap sequencer
interface trap_ctrl_if;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic [31:0] mem_inst;
    logic [31:0] mem_addr;
    logic        exc_inst_mis;
    logic        exc_illegal;
    logic        exc_ebreak;
    logic        exc_ecall;
    logic        exc_load_mis;
    logic        exc_store_mis;
    logic        mem_mret;
    logic        ext_irq;
    logic [31:0] mstatus;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;
    logic [31:0] mcause_cur;
    logic [31:0] mtval_cur;
    logic        csr_w;
    logic        trap;
    logic        mret;
    logic [31:0] mepc_in;
    logic [31:0] mcause_in;
    logic [31:0] mtval_in;
    logic        busy;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output mem_valid, mem_pc, mem_inst, mem_addr,
        output exc_inst_mis, exc_illegal, exc_ebreak, exc_ecall, exc_load_mis, exc_store_mis,
        output mem_mret, ext_irq, mstatus, mtvec_out, mepc_out, mcause_cur, mtval_cur, csr_w,
        input  trap, mret, mepc_in, mcause_in, mtval_in, busy, flush, redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_valid, mem_pc, mem_inst, mem_addr,
        input  exc_inst_mis, exc_illegal, exc_ebreak, exc_ecall, exc_load_mis, exc_store_mis,
        input  mem_mret, ext_irq, mstatus, mtvec_out, mepc_out, mcause_cur, mtval_cur, csr_w,
        output trap, mret, mepc_in, mcause_in, mtval_in, busy, flush, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap/mret sequencer: latch event, commit to CSRs, redirect PC
module trap_ctrl #(
    parameter bit          VECTORED_EN = 1'b1,
    parameter logic [31:0] IRQ_CAUSE   = 32'h8000000B
) (
    input  logic       clk,
    input  logic       rst,
    trap_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, T_COMMIT, M_COMMIT, REDIRECT} state_t;

    state_t      state, state_nxt;
    logic [31:0] cause_q, cause_nxt;
    logic [31:0] epc_q, epc_nxt;
    logic [31:0] tval_q, tval_nxt;
    logic [31:0] tgt_q, tgt_nxt;
    logic        take_trap;
    logic [31:0] trap_base;
    logic [31:0] trap_target;
    logic        unused;

    assign trap_base   = {bus.mtvec_out[31:2], 2'b00};
    assign trap_target = (VECTORED_EN && cause_q[31] && bus.mtvec_out[1:0] == 2'b01)
                         ? trap_base + {cause_q[29:0], 2'b00} : trap_base;

    always_comb begin
        state_nxt = state;
        cause_nxt = cause_q;
        epc_nxt   = epc_q;
        tval_nxt  = tval_q;
        tgt_nxt   = tgt_q;
        take_trap = 1'b1;
        case (state)
            IDLE: begin
                if (bus.mem_valid) begin
                    if (bus.ext_irq && bus.mstatus[3]) begin
                        cause_nxt = IRQ_CAUSE;     tval_nxt = 32'd0;
                    end else if (bus.exc_inst_mis) begin
                        cause_nxt = 32'd0;         tval_nxt = bus.mem_pc;
                    end else if (bus.exc_illegal) begin
                        cause_nxt = 32'd2;         tval_nxt = bus.mem_inst;
                    end else if (bus.exc_ebreak) begin
                        cause_nxt = 32'd3;         tval_nxt = bus.mem_pc;
                    end else if (bus.exc_ecall) begin
                        cause_nxt = 32'd11;        tval_nxt = 32'd0;
                    end else if (bus.exc_load_mis) begin
                        cause_nxt = 32'd4;         tval_nxt = bus.mem_addr;
                    end else if (bus.exc_store_mis) begin
                        cause_nxt = 32'd6;         tval_nxt = bus.mem_addr;
                    end else begin
                        take_trap = 1'b0;
                        if (bus.mem_mret) begin
                            tgt_nxt   = bus.mepc_out;
                            state_nxt = M_COMMIT;
                        end
                    end
                    if (take_trap) begin
                        epc_nxt   = bus.mem_pc;
                        state_nxt = T_COMMIT;
                    end
                end
            end
            T_COMMIT: begin
                // mtvec is sampled at commit so a same-cycle-earlier CSR write is seen
                if (!bus.csr_w) begin
                    tgt_nxt   = trap_target;
                    state_nxt = REDIRECT;
                end
            end
            M_COMMIT: begin
                if (!bus.csr_w) state_nxt = REDIRECT;
            end
            REDIRECT: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cause_q <= 32'd0;
            epc_q   <= 32'd0;
            tval_q  <= 32'd0;
            tgt_q   <= 32'd0;
        end else begin
            state   <= state_nxt;
            cause_q <= cause_nxt;
            epc_q   <= epc_nxt;
            tval_q  <= tval_nxt;
            tgt_q   <= tgt_nxt;
        end
    end

    // Commit strobes are qualified by csr_w in the same cycle the CSR file samples them
    assign bus.trap           = (state == T_COMMIT) && !bus.csr_w;
    assign bus.mret           = (state == M_COMMIT) && !bus.csr_w;
    assign bus.busy           = (state != IDLE);
    assign bus.flush          = (state == REDIRECT);
    assign bus.redirect_valid = (state == REDIRECT);
    assign bus.redirect_pc    = (state == REDIRECT) ? tgt_q : 32'd0;
    assign bus.mepc_in        = (state == M_COMMIT) ? bus.mepc_out   : epc_q;
    assign bus.mcause_in      = (state == M_COMMIT) ? bus.mcause_cur : cause_q;
    assign bus.mtval_in       = (state == M_COMMIT) ? bus.mtval_cur  : tval_q;

    assign unused = ^{bus.mstatus[31:4], bus.mstatus[2:0], cause_q[30]};
endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - table, hand-written and randomized checks of trap_ctrl
module tb_trap_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trap_ctrl_if bus ();
    trap_ctrl #(.VECTORED_EN(1'b1), .IRQ_CAUSE(32'h8000000B)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit        valid;
        bit        irq;
        bit        mie;
        bit [5:0]  exc;
        bit        mret;
        bit [31:0] pc;
        bit [31:0] inst;
        bit [31:0] addr;
        bit [31:0] mtvec;
        bit [31:0] mepc;
    } vec_t;

    typedef struct {
        int        kind;
        bit [31:0] cause;
        bit [31:0] tval;
        bit [31:0] target;
    } exp_t;

    typedef struct {
        vec_t v;
        int   hold;
        exp_t e;
    } tv_t;

    int n_cmp = 0;
    int n_bad = 0;
    bit [31:0] mcur = 32'h55;
    bit [31:0] tcur = 32'h66;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(vec_t v);
        exp_t e;
        bit [31:0] codes [6];
        bit [31:0] tvals [6];
        bit [31:0] base;
        codes = '{32'd0, 32'd2, 32'd3, 32'd11, 32'd4, 32'd6};
        tvals = '{v.pc, v.inst, v.pc, 32'd0, v.addr, v.addr};
        e = '{0, 32'd0, 32'd0, 32'd0};
        if (!v.valid) return e;
        if (v.irq && v.mie) begin
            e.kind = 1; e.cause = 32'h8000000B; e.tval = 0;
        end else begin
            for (int i = 0; i < 6; i++)
                if (v.exc[i] && e.kind == 0) begin
                    e.kind = 1; e.cause = codes[i]; e.tval = tvals[i];
                end
        end
        if (e.kind == 0 && v.mret) begin
            e.kind = 2; e.target = v.mepc;
        end else if (e.kind == 1) begin
            base = v.mtvec & ~32'h3;
            e.target = (e.cause[31] && v.mtvec[1:0] == 2'b01)
                       ? base + 32'd4 * (e.cause & 32'h7fffffff) : base;
        end
        return e;
    endfunction

    task automatic drive(vec_t v);
        bus.mem_valid     = v.valid;
        bus.mem_pc        = v.pc;
        bus.mem_inst      = v.inst;
        bus.mem_addr      = v.addr;
        bus.exc_inst_mis  = v.exc[0];
        bus.exc_illegal   = v.exc[1];
        bus.exc_ebreak    = v.exc[2];
        bus.exc_ecall     = v.exc[3];
        bus.exc_load_mis  = v.exc[4];
        bus.exc_store_mis = v.exc[5];
        bus.mem_mret      = v.mret;
        bus.ext_irq       = v.irq;
        bus.mstatus       = v.mie ? 32'h8 : 32'h0;
        bus.mtvec_out     = v.mtvec;
        bus.mepc_out      = v.mepc;
        bus.mcause_cur    = mcur;
        bus.mtval_cur     = tcur;
    endtask

    // mem_* stay asserted while busy (they must be ignored); ext_irq drops right after detect
    task automatic run(input string tag, input vec_t v, input int hold, input exp_t e);
        @(negedge clk);
        bus.csr_w = 1'b0;
        drive(v);
        #1 chk({tag, " busy@detect"}, bus.busy, 1'b0);
        @(negedge clk);
        bus.ext_irq = 1'b0;
        if (e.kind == 0) begin
            bus.mem_valid = 1'b0;
            #1 chk({tag, " busy@idle"}, bus.busy, 1'b0);
            chk({tag, " trap@idle"}, bus.trap, 1'b0);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            bus.csr_w = 1'b1;
            #1 chk({tag, " hold strobe"}, {bus.trap, bus.mret}, 2'b00);
            chk({tag, " hold busy"}, bus.busy, 1'b1);
            @(negedge clk);
        end
        bus.csr_w = 1'b0;
        #1;
        chk({tag, " trap"}, bus.trap, e.kind == 1);
        chk({tag, " mret"}, bus.mret, e.kind == 2);
        chk({tag, " mepc_in"}, bus.mepc_in, e.kind == 1 ? v.pc : v.mepc);
        chk({tag, " mcause_in"}, bus.mcause_in, e.kind == 1 ? e.cause : mcur);
        chk({tag, " mtval_in"}, bus.mtval_in, e.kind == 1 ? e.tval : tcur);
        @(negedge clk);
        #1;
        chk({tag, " redirect"}, {bus.flush, bus.redirect_valid, bus.busy, bus.trap, bus.mret}, 5'b11100);
        chk({tag, " redirect_pc"}, bus.redirect_pc, e.target);
        @(negedge clk);
        bus.mem_valid = 1'b0;
        #1 chk({tag, " back idle"}, {bus.busy, bus.flush, bus.redirect_valid}, 3'b000);
    endtask

    tv_t  tbl [10];
    vec_t rv;
    exp_t re;

    initial begin
        vec_t z;
        z = '{0, 0, 0, 6'b0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        drive(z);
        bus.csr_w = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("reset outs", {bus.trap, bus.mret, bus.busy, bus.flush, bus.redirect_valid}, 5'b0);
        chk("reset pc/csr", bus.redirect_pc | bus.mepc_in | bus.mcause_in | bus.mtval_in, 32'd0);

        tbl[0] = '{'{1,0,0,6'b001000,0,32'h100,32'h0,32'h0,32'h200,32'h0}, 0, '{1,32'd11,32'h0,32'h200}};
        tbl[1] = '{'{1,0,0,6'b010010,0,32'h104,32'hFFFFFFFF,32'h13,32'h200,32'h0}, 0, '{1,32'd2,32'hFFFFFFFF,32'h200}};
        tbl[2] = '{'{1,1,1,6'b001000,0,32'h40,32'h0,32'h0,32'h301,32'h0}, 0, '{1,32'h8000000B,32'h0,32'h32C}};
        tbl[3] = '{'{1,1,0,6'b001000,0,32'h40,32'h0,32'h0,32'h301,32'h0}, 0, '{1,32'd11,32'h0,32'h300}};
        tbl[4] = '{'{1,0,0,6'b000000,1,32'h500,32'h0,32'h0,32'h200,32'h88}, 3, '{2,32'h0,32'h0,32'h88}};
        tbl[5] = '{'{0,0,0,6'b000010,0,32'h600,32'h0,32'h0,32'h200,32'h0}, 0, '{0,32'h0,32'h0,32'h0}};
        tbl[6] = '{'{1,0,0,6'b000100,1,32'h2000,32'h0,32'h0,32'h200,32'h99}, 1, '{1,32'd3,32'h2000,32'h200}};
        tbl[7] = '{'{1,0,0,6'b100000,0,32'h700,32'h0,32'h777,32'h401,32'h0}, 2, '{1,32'd6,32'h777,32'h400}};
        tbl[8] = '{'{1,0,0,6'b000001,0,32'h3002,32'h0,32'h0,32'h200,32'h0}, 0, '{1,32'd0,32'h3002,32'h200}};
        tbl[9] = '{'{1,1,0,6'b000000,0,32'h800,32'h0,32'h0,32'h200,32'h0}, 0, '{0,32'h0,32'h0,32'h0}};
        for (int i = 0; i < 10; i++)
            run($sformatf("tbl%0d", i), tbl[i].v, tbl[i].hold, tbl[i].e);

        // reset while waiting in T_COMMIT aborts the trap
        @(negedge clk);
        drive(tbl[0].v);
        @(negedge clk);
        bus.mem_valid = 1'b0;
        bus.csr_w = 1'b1;
        #1 chk("rst pre busy", bus.busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.csr_w = 1'b0;
        #1 chk("rst outs", {bus.trap, bus.mret, bus.busy, bus.flush, bus.redirect_valid}, 5'b0);
        chk("rst pc/csr", bus.redirect_pc | bus.mepc_in | bus.mcause_in | bus.mtval_in, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 chk("rst no pulse", {bus.trap, bus.busy, bus.flush}, 3'b000);
        end

        for (int n = 0; n < 200; n++) begin
            rv.valid = ($urandom_range(0, 7) != 0);
            rv.irq   = ($urandom_range(0, 2) == 0);
            rv.mie   = $urandom_range(0, 1) == 1;
            rv.exc   = 6'($urandom & $urandom);
            rv.mret  = $urandom_range(0, 2) == 0;
            rv.pc    = $urandom;
            rv.inst  = $urandom;
            rv.addr  = $urandom;
            rv.mtvec = {30'($urandom), 1'b0, 1'($urandom)};
            rv.mepc  = $urandom;
            mcur     = $urandom;
            tcur     = $urandom;
            re = model(rv);
            run($sformatf("rnd%0d", n), rv, $urandom_range(0, 3), re);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
